// File: rtl/sevseg_pkg.sv
// ---------------------------------------------------------------------------
// sevseg_pkg
// Shared definitions for the 7-segment display driver family.
//  - seg_t         : active-low segment vector, bit 0 = a .. bit 6 = g
//  - SEG_BLANK     : all segments off
//  - HEX_SEG_TABLE : hex digit -> active-low segment pattern, entry 0 is the
//                    least significant element of the packed array
// ---------------------------------------------------------------------------
package sevseg_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'h7F;

    // Listed from F down to 0 so that HEX_SEG_TABLE[n] is the pattern for n.
    localparam logic [15:0][6:0] HEX_SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/seven_seg_hex_decoder.sv
// ---------------------------------------------------------------------------
// seven_seg_hex_decoder
// Purely combinational hex-to-segment decoder for a common-anode display.
// Ports:
//  value  in   4   hex digit to show
//  seg    out  7   active-low segments, seg[0]=a .. seg[6]=g
// ---------------------------------------------------------------------------
module seven_seg_hex_decoder
    import sevseg_pkg::*;
(
    input  logic [3:0] value,
    output seg_t       seg
);

    assign seg = HEX_SEG_TABLE[value];

endmodule

// File: rtl/seven_seg_scan_driver.sv
// ---------------------------------------------------------------------------
// seven_seg_scan_driver
// Time-multiplexed driver for a common-anode 7-segment display. One digit is
// lit per slot; each slot starts with a short all-anodes-off window to stop
// ghosting. New values are staged by 'load' and only copied into the display
// shadow at a frame boundary, so a frame never mixes old and new data.
//
// Optional feature: define SEVSEG_LZB_EN for leading-zero blanking. The blank
// mask is taken from the data entering the shadow at the frame boundary and is
// held for the whole frame. Without the macro, zeros are always displayed and
// only digit_en blanks a digit.
//
// Ports:
//  clk         in   1             system clock
//  rst         in   1             asynchronous, active-high reset
//  digits_in   in   4*NUM_DIGITS  hex value per digit, [3:0] = digit 0
//  digit_en    in   NUM_DIGITS    1 = digit lit
//  dp_in       in   NUM_DIGITS    1 = decimal point lit
//  load        in   1             strobe capturing digits_in/digit_en/dp_in
//  frame_done  out  1             pulse in the cycle the last slot ends
//  applied     out  1             pulse in the cycle new data enters the shadow
//  seg         out  7             active-low segments
//  dp          out  1             active-low decimal point
//  an          out  NUM_DIGITS    active-low anodes, an[0] = digit 0
// ---------------------------------------------------------------------------
module seven_seg_scan_driver
    import sevseg_pkg::*;
#(
    parameter int NUM_DIGITS  = 8,
    parameter int DIGIT_TICKS = 100_000,
    parameter int BLANK_TICKS = 2_000
)
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    output logic                    frame_done,
    output logic                    applied,
    output seg_t                    seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an
);

    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int TICK_W = $clog2(DIGIT_TICKS);

    localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(DIGIT_TICKS - 1);
    localparam logic [TICK_W-1:0] TICK_BLANK = TICK_W'(BLANK_TICKS);
    localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    logic [TICK_W-1:0] tick;
    logic [IDX_W-1:0]  idx;
    logic              slot_end;
    logic              frame_boundary;

    logic [NUM_DIGITS-1:0][3:0] staging_digits;
    logic [NUM_DIGITS-1:0]      staging_en;
    logic [NUM_DIGITS-1:0]      staging_dp;
    logic                       pending;

    logic [NUM_DIGITS-1:0][3:0] shadow_digits;
    logic [NUM_DIGITS-1:0]      shadow_en;
    logic [NUM_DIGITS-1:0]      shadow_dp;
    logic [NUM_DIGITS-1:0][3:0] shadow_digits_next;
    logic [NUM_DIGITS-1:0]      shadow_en_next;
    logic [NUM_DIGITS-1:0]      shadow_dp_next;
    logic                       take_live;
    logic                       take_staged;

    logic [NUM_DIGITS-1:0] digit_lit;
    logic [NUM_DIGITS-1:0] an_next;
    seg_t                  decoded_seg;

    assign slot_end       = (tick == TICK_LAST);
    assign frame_boundary = slot_end && (idx == IDX_LAST);
    assign frame_done     = frame_boundary;

    // A load landing exactly on the boundary bypasses staging; otherwise any
    // pending staged data is promoted at the boundary.
    assign take_live   = frame_boundary && load;
    assign take_staged = frame_boundary && !load && pending;
    assign applied     = take_live || take_staged;

    // Slot timing: tick runs through one slot, idx advances per slot and
    // wraps after the last digit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick <= '0;
            idx  <= '0;
        end else if (slot_end) begin
            tick <= '0;
            idx  <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            tick <= tick + 1'b1;
        end
    end

    // Staging holds the most recent load until the next boundary. The
    // boundary always empties it, either by promoting it or because a
    // coincident load supersedes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            staging_digits <= '0;
            staging_en     <= '0;
            staging_dp     <= '0;
            pending        <= 1'b0;
        end else if (frame_boundary) begin
            pending <= 1'b0;
        end else if (load) begin
            staging_digits <= digits_in;
            staging_en     <= digit_en;
            staging_dp     <= dp_in;
            pending        <= 1'b1;
        end
    end

    // Value the shadow will hold for the next frame.
    always_comb begin
        shadow_digits_next = shadow_digits;
        shadow_en_next     = shadow_en;
        shadow_dp_next     = shadow_dp;
        if (take_live) begin
            shadow_digits_next = digits_in;
            shadow_en_next     = digit_en;
            shadow_dp_next     = dp_in;
        end else if (take_staged) begin
            shadow_digits_next = staging_digits;
            shadow_en_next     = staging_en;
            shadow_dp_next     = staging_dp;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_digits <= '0;
            shadow_en     <= '0;
            shadow_dp     <= '0;
        end else begin
            shadow_digits <= shadow_digits_next;
            shadow_en     <= shadow_en_next;
            shadow_dp     <= shadow_dp_next;
        end
    end

`ifdef SEVSEG_LZB_EN
    logic [NUM_DIGITS-1:0] lzb_mask;
    logic [NUM_DIGITS-1:0] lzb_mask_next;
    logic                  zero_above;

    // Walk down from the most significant digit: a zero is blanked while no
    // enabled non-zero digit has been seen above it. Digit 0 is never visited.
    always_comb begin
        lzb_mask_next = '0;
        zero_above    = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            if ((shadow_digits_next[k] == 4'h0) && zero_above) begin
                lzb_mask_next[k] = 1'b1;
            end
            if (shadow_en_next[k] && (shadow_digits_next[k] != 4'h0)) begin
                zero_above = 1'b0;
            end
        end
    end

    // Latched only at the boundary so the mask cannot change mid-frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lzb_mask <= '0;
        end else if (frame_boundary) begin
            lzb_mask <= lzb_mask_next;
        end
    end

    assign digit_lit = shadow_en & ~lzb_mask;
`else
    assign digit_lit = shadow_en;
`endif

    seven_seg_hex_decoder u_hex_decoder (
        .value (shadow_digits[idx]),
        .seg   (decoded_seg)
    );

    // Anodes stay off for the first BLANK_TICKS of every slot.
    always_comb begin
        an_next = '1;
        if (tick >= TICK_BLANK) begin
            an_next[idx] = 1'b0;
        end
    end

    // Registered output stage, one cycle behind the tick/idx state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg <= SEG_BLANK;
            dp  <= 1'b1;
            an  <= '1;
        end else begin
            an  <= an_next;
            seg <= digit_lit[idx] ? decoded_seg : SEG_BLANK;
            dp  <= ~shadow_dp[idx];
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_seven_seg_scan_driver
// Directed self-checking bench for seven_seg_scan_driver with 4 digits,
// 4 ticks per slot and 1 blanking tick, so one frame is 16 cycles.
// Outputs are sampled on the falling edge; inputs change on the falling edge.
// ---------------------------------------------------------------------------
module tb_seven_seg_scan_driver;

    localparam int NUM_DIGITS  = 4;
    localparam int DIGIT_TICKS = 4;
    localparam int BLANK_TICKS = 1;
    localparam int FRAME       = NUM_DIGITS * DIGIT_TICKS;

`ifdef SEVSEG_LZB_EN
    localparam logic [6:0]      SLOT3_0BEF = 7'h7F;
    localparam logic [3:0][6:0] ZEROS_SEG  = {7'h7F, 7'h7F, 7'h7F, 7'h40};
`else
    localparam logic [6:0]      SLOT3_0BEF = 7'h40;
    localparam logic [3:0][6:0] ZEROS_SEG  = {7'h40, 7'h40, 7'h40, 7'h40};
`endif

    localparam logic [3:0][6:0] BLANK_SEG = {7'h7F, 7'h7F, 7'h7F, 7'h7F};
    localparam logic [3:0][6:0] SEG_1234  = {7'h79, 7'h24, 7'h30, 7'h19};
    localparam logic [3:0][6:0] SEG_5555  = {7'h12, 7'h12, 7'h12, 7'h12};
    localparam logic [3:0][6:0] SEG_0BEF  = {SLOT3_0BEF, 7'h03, 7'h06, 7'h0E};

    logic                    clk;
    logic                    rst;
    logic [4*NUM_DIGITS-1:0] digits_in;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic                    load;
    logic                    frame_done;
    logic                    applied;
    logic [6:0]              seg;
    logic                    dp;
    logic [NUM_DIGITS-1:0]   an;

    int num_checks   = 0;
    int num_failures = 0;

    logic [3:0] stim_en;
    logic [3:0] stim_dp;

    seven_seg_scan_driver #(
        .NUM_DIGITS  (NUM_DIGITS),
        .DIGIT_TICKS (DIGIT_TICKS),
        .BLANK_TICKS (BLANK_TICKS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .digits_in  (digits_in),
        .digit_en   (digit_en),
        .dp_in      (dp_in),
        .load       (load),
        .frame_done (frame_done),
        .applied    (applied),
        .seg        (seg),
        .dp         (dp),
        .an         (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        num_checks++;
        if (actual !== expected) begin
            num_failures++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Drives one set of display inputs with load raised; caller drops load.
    task automatic applyStimulus(input logic [15:0] data, input logic [3:0] en,
                                 input logic [3:0] dpv);
        digits_in = data;
        digit_en  = en;
        dp_in     = dpv;
        load      = 1'b1;
    endtask

    // Called right after reset release; waits for the first boundary while
    // checking the display stays blank, and checks when it arrives.
    task automatic waitFirstBoundary(input string tag);
        int  cnt;
        bit  found;
        cnt   = 0;
        found = 1'b0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            @(negedge clk);
            cnt++;
            checkOutput({tag, "_seg_blank"}, seg, 7'h7F);
            checkOutput({tag, "_dp_off"}, dp, 1'b1);
            if (frame_done) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput({tag, "_boundary_seen"}, found, 1'b1);
        checkOutput({tag, "_boundary_cycle"}, cnt, FRAME - 1);
        checkOutput({tag, "_applied"}, applied, 1'b0);
    endtask

    // Entered in a boundary cycle; checks the whole following frame and ends
    // in the next boundary cycle. Up to two loads can be scheduled by cycle.
    task automatic checkFrame(input string tag, input logic [3:0][6:0] exp_seg,
                              input logic [3:0] exp_dp, input logic exp_applied,
                              input int cyc_a, input logic [15:0] data_a,
                              input int cyc_b, input logic [15:0] data_b);
        int         j;
        int         slot;
        int         t;
        logic [3:0] exp_an;
        for (int s = 0; s < FRAME; s++) begin
            @(negedge clk);
            if (s > 0) begin
                j      = s - 1;
                slot   = j / DIGIT_TICKS;
                t      = j % DIGIT_TICKS;
                exp_an = 4'hF;
                if (t >= BLANK_TICKS) begin
                    exp_an[slot] = 1'b0;
                    checkOutput({tag, "_seg"}, seg, exp_seg[slot]);
                    checkOutput({tag, "_dp"}, dp, exp_dp[slot]);
                end
                checkOutput({tag, "_an"}, an, exp_an);
            end
            checkOutput({tag, "_frame_done"}, frame_done, (s == FRAME - 1));
            checkOutput({tag, "_applied"}, applied, (s == FRAME - 1) && exp_applied);
            if (s == cyc_a) begin
                applyStimulus(data_a, stim_en, stim_dp);
            end else if (s == cyc_b) begin
                applyStimulus(data_b, stim_en, stim_dp);
            end else begin
                load = 1'b0;
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        load      = 1'b0;
        digits_in = '0;
        digit_en  = '0;
        dp_in     = '0;
        stim_en   = 4'hF;
        stim_dp   = 4'b0101;

        // Reset values while reset is held.
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_seg", seg, 7'h7F);
        checkOutput("reset_dp", dp, 1'b1);
        checkOutput("reset_an", an, 4'hF);
        checkOutput("reset_frame_done", frame_done, 1'b0);
        checkOutput("reset_applied", applied, 1'b0);
        rst = 1'b0;

        waitFirstBoundary("startup");

        // Blank frame with 1234 loaded mid-frame; decimal points on 0 and 2.
        checkFrame("blank_frame", BLANK_SEG, 4'hF, 1'b1, 2, 16'h1234, -1, 16'h0);

        // 1234 displayed; AAAA then 5555 staged, only the last should land.
        checkFrame("hex_1234", SEG_1234, 4'b1010, 1'b1, 3, 16'hAAAA, 9, 16'h5555);

        checkFrame("hex_5555", SEG_5555, 4'b1010, 1'b0, -1, 16'h0, -1, 16'h0);

        // Load exactly on the boundary cycle goes straight to the shadow.
        stim_dp = 4'b0000;
        applyStimulus(16'h0BEF, 4'hF, 4'h0);
        #1;
        checkOutput("boundary_load_applied", applied, 1'b1);
        checkOutput("boundary_load_frame_done", frame_done, 1'b1);

        checkFrame("hex_0BEF", SEG_0BEF, 4'hF, 1'b1, 4, 16'h0000, -1, 16'h0);

        // All zeros, then everything disabled.
        stim_en = 4'h0;
        checkFrame("zeros", ZEROS_SEG, 4'hF, 1'b1, 4, 16'h0000, -1, 16'h0);

        stim_en = 4'hF;
        stim_dp = 4'b0101;
        checkFrame("disabled", BLANK_SEG, 4'hF, 1'b1, 3, 16'h1234, -1, 16'h0);

        checkFrame("reload_1234", SEG_1234, 4'b1010, 1'b0, -1, 16'h0, -1, 16'h0);

        // Stage 5555, then reset mid-slot: outputs clear at once and the
        // staged data never reaches the display.
        repeat (3) @(negedge clk);
        applyStimulus(16'h5555, 4'hF, 4'h0);
        @(negedge clk);
        load = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("pre_reset_seg_lit", seg, 7'h30);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_reset_seg", seg, 7'h7F);
        checkOutput("async_reset_an", an, 4'hF);
        checkOutput("async_reset_dp", dp, 1'b1);
        checkOutput("async_reset_frame_done", frame_done, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        waitFirstBoundary("after_reset");
        checkFrame("after_reset_blank", BLANK_SEG, 4'hF, 1'b0, -1, 16'h0, -1, 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 num_checks, num_failures);
        $finish;
    end

endmodule
